// File: rtl/dot_seq_pkg.sv
// Shared constants, FSM state type and lane packing helper for the dot-product sequencer.
package dot_seq_pkg;

  localparam int LANES = 8;
  localparam int DW    = 32;
  localparam int ACC_W = 64;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_WAIT_LOW,
    S_WAIT_HIGH,
    S_ACCUM,
    S_FINISH
  } state_t;

  // Bit offset of a lane inside a packed multi-lane operand bus.
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/dot_seq_operand_buf.sv
// Two MAX_LEN-deep operand register files with an 8-lane chunk read port.
// Lanes whose element index falls at or beyond len_i read as zero.
module dot_seq_operand_buf #(
  parameter int MAX_LEN = 64,
  parameter int DW      = dot_seq_pkg::DW,
  parameter int CW      = 3
) (
  input  logic                                 clk,
  input  logic                                 wr_en_i,
  input  logic                                 wr_sel_i,
  input  logic [$clog2(MAX_LEN)-1:0]           wr_addr_i,
  input  logic [DW-1:0]                        wr_data_i,
  input  logic [CW-1:0]                        chunk_i,
  input  logic [$clog2(MAX_LEN+1)-1:0]         len_i,
  output logic [dot_seq_pkg::LANES*DW-1:0]     lanes_a_o,
  output logic [dot_seq_pkg::LANES*DW-1:0]     lanes_b_o
);
  import dot_seq_pkg::*;

  localparam int AW = $clog2(MAX_LEN);

  logic [DW-1:0] a_mem [MAX_LEN];
  logic [DW-1:0] b_mem [MAX_LEN];

  // Guard keeps non-power-of-two depths from writing past the array.
  always_ff @(posedge clk) begin
    if (wr_en_i && (32'(wr_addr_i) < MAX_LEN)) begin
      if (wr_sel_i) begin
        b_mem[wr_addr_i] <= wr_data_i;
      end else begin
        a_mem[wr_addr_i] <= wr_data_i;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      localparam int LSB = lane_lsb(gi, DW);
      logic [AW:0]   idx;
      logic          in_range;
      logic [AW-1:0] rd_idx;

      assign idx      = (AW+1)'(chunk_i) * (AW+1)'(LANES) + (AW+1)'(gi);
      assign in_range = 32'(idx) < 32'(len_i);
      assign rd_idx   = in_range ? idx[AW-1:0] : '0;

      assign lanes_a_o[LSB +: DW] = in_range ? a_mem[rd_idx] : '0;
      assign lanes_b_o[LSB +: DW] = in_range ? b_mem[rd_idx] : '0;
    end
  endgenerate

endmodule

// File: rtl/dot_seq_ctrl.sv
// Sequencer that splits a dot product into 8-element chunks for dot_product_accel
// and accumulates the per-chunk partial sums into one signed result.
module dot_seq_ctrl #(
  parameter int MAX_LEN = 64,
  parameter int TIMEOUT = 1024,
  parameter int DW      = dot_seq_pkg::DW,
  parameter int ACC_W   = dot_seq_pkg::ACC_W
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             wr_en,
  input  logic                             wr_sel,
  input  logic [$clog2(MAX_LEN)-1:0]       wr_addr,
  input  logic [DW-1:0]                    wr_data,
  input  logic [$clog2(MAX_LEN+1)-1:0]     len,
  input  logic                             start,
  output logic                             busy,
  output logic                             done,
  output logic                             err,
  output logic [ACC_W-1:0]                 result,
  output logic                             acc_start,
  input  logic                             acc_done,
  output logic [dot_seq_pkg::LANES*DW-1:0] acc_a,
  output logic [dot_seq_pkg::LANES*DW-1:0] acc_b,
  input  logic [ACC_W-1:0]                 acc_result
);
  import dot_seq_pkg::*;

  localparam int LW     = $clog2(MAX_LEN + 1);
  localparam int NCHUNK = MAX_LEN / LANES;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int TW     = $clog2(TIMEOUT + 1);
  localparam logic [LW-1:0] MAX_LEN_L = LW'(MAX_LEN);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

  state_t                  state_q, state_d;
  logic [LW-1:0]           len_q, len_d;
  logic [CW-1:0]           chunk_q, chunk_d;
  logic [ACC_W-1:0]        sum_q, sum_d;
  logic [ACC_W-1:0]        result_q, result_d;
  logic [LANES*DW-1:0]     acc_a_q, acc_a_d;
  logic [LANES*DW-1:0]     acc_b_q, acc_b_d;
  logic [TW-1:0]           tmo_q, tmo_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;

  logic [LANES*DW-1:0]     buf_a, buf_b;
  logic [LW:0]             next_base;
  logic                    last_chunk;

  // Writes are only honoured in IDLE so a run always sees a frozen buffer.
  dot_seq_operand_buf #(
    .MAX_LEN (MAX_LEN),
    .DW      (DW),
    .CW      (CW)
  ) u_buf (
    .clk       (clk),
    .wr_en_i   (wr_en && (state_q == S_IDLE)),
    .wr_sel_i  (wr_sel),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .chunk_i   (chunk_q),
    .len_i     (len_q),
    .lanes_a_o (buf_a),
    .lanes_b_o (buf_b)
  );

  assign next_base  = (LW+1)'(chunk_q) * (LW+1)'(LANES) + (LW+1)'(LANES);
  assign last_chunk = next_base >= {1'b0, len_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      len_q    <= '0;
      chunk_q  <= '0;
      sum_q    <= '0;
      result_q <= '0;
      acc_a_q  <= '0;
      acc_b_q  <= '0;
      tmo_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      chunk_q  <= chunk_d;
      sum_q    <= sum_d;
      result_q <= result_d;
      acc_a_q  <= acc_a_d;
      acc_b_q  <= acc_b_d;
      tmo_q    <= tmo_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    chunk_d  = chunk_q;
    sum_d    = sum_q;
    result_d = result_q;
    acc_a_d  = acc_a_q;
    acc_b_d  = acc_b_q;
    tmo_d    = tmo_q;
    done_d   = 1'b0;
    err_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len > MAX_LEN_L) begin
            err_d = 1'b1;
          end else begin
            len_d   = len;
            sum_d   = '0;
            chunk_d = '0;
            state_d = (len == '0) ? S_FINISH : S_LOAD;
          end
        end
      end
      S_LOAD: begin
        acc_a_d = buf_a;
        acc_b_d = buf_b;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        tmo_d   = '0;
        state_d = S_WAIT_LOW;
      end
      // Done is a level that lingers from the previous op, so see it drop first.
      S_WAIT_LOW: begin
        if (!acc_done) begin
          tmo_d   = '0;
          state_d = S_WAIT_HIGH;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_WAIT_HIGH: begin
        if (acc_done) begin
          state_d = S_ACCUM;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_ACCUM: begin
        sum_d = sum_q + acc_result;
        if (last_chunk) begin
          state_d = S_FINISH;
        end else begin
          chunk_d = chunk_q + 1'b1;
          state_d = S_LOAD;
        end
      end
      S_FINISH: begin
        result_d = sum_q;
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Done/err are registered alongside result so all three change together.
  assign busy      = (state_q != S_IDLE);
  assign acc_start = (state_q == S_ISSUE);
  assign done      = done_q;
  assign err       = err_q;
  assign result    = result_q;
  assign acc_a     = acc_a_q;
  assign acc_b     = acc_b_q;

endmodule

// File: tb/tb_dot_seq_ctrl.sv
// Directed plus randomized bench for dot_seq_ctrl with a behavioural accelerator
// and an element-wise reference dot product.
module tb_dot_seq_ctrl;

  localparam int MAX_LEN = 64;
  localparam int TIMEOUT = 1024;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         wr_en;
  logic         wr_sel;
  logic [5:0]   wr_addr;
  logic [31:0]  wr_data;
  logic [6:0]   len;
  logic         start;
  logic         busy;
  logic         done;
  logic         err;
  logic [63:0]  result;
  logic         acc_start;
  logic         acc_done;
  logic [255:0] acc_a;
  logic [255:0] acc_b;
  logic [63:0]  acc_result;

  int checks = 0;
  int errors = 0;

  int ref_a [MAX_LEN];
  int ref_b [MAX_LEN];

  int mon_starts, mon_done, mon_err;
  logic [255:0] last_a, last_b;
  bit acc_hold_low = 1'b0;
  int run_cycles;

  dot_seq_ctrl #(.MAX_LEN(MAX_LEN), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_sel     (wr_sel),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .len        (len),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .result     (result),
    .acc_start  (acc_start),
    .acc_done   (acc_done),
    .acc_a      (acc_a),
    .acc_b      (acc_b),
    .acc_result (acc_result)
  );

  initial forever #5 clk = ~clk;

  function automatic longint ref_dot(input int n);
    longint s = 0;
    for (int i = 0; i < n; i++) s += longint'(ref_a[i]) * longint'(ref_b[i]);
    return s;
  endfunction

  function automatic longint lanes_dot(input logic [255:0] a, input logic [255:0] b);
    longint s = 0;
    for (int i = 0; i < 8; i++) s += longint'($signed(a[i*32 +: 32])) * longint'($signed(b[i*32 +: 32]));
    return s;
  endfunction

  // Accelerator stand-in: done drops a little after start, rises later with the lane dot product.
  initial begin
    int lo_cnt, hi_cnt;
    longint pend;
    lo_cnt = 0; hi_cnt = 0; pend = 0;
    acc_done = 1'b1;
    acc_result = 64'd0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        lo_cnt = 0; hi_cnt = 0;
      end else if (acc_start) begin
        pend   = lanes_dot(acc_a, acc_b);
        lo_cnt = 1 + int'($urandom_range(0, 1));
        hi_cnt = lo_cnt + 1 + int'($urandom_range(0, 3));
      end else begin
        if (lo_cnt > 0) begin
          lo_cnt--;
          if (lo_cnt == 0) acc_done = 1'b0;
        end
        if (hi_cnt > 0) begin
          hi_cnt--;
          if (hi_cnt == 0 && !acc_hold_low) begin
            acc_done = 1'b1;
            acc_result = 64'(pend);
          end
        end
      end
      if (acc_hold_low) acc_done = 1'b0;
    end
  end

  initial forever begin
    @(negedge clk);
    if (acc_start) begin
      mon_starts++;
      last_a = acc_a;
      last_b = acc_b;
    end
    if (done) mon_done++;
    if (err) mon_err++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input bit sel, input int addr, input int data);
    wr_en = 1'b1; wr_sel = sel; wr_addr = 6'(addr); wr_data = data;
    @(negedge clk);
    wr_en = 1'b0;
    if (sel) ref_b[addr] = data; else ref_a[addr] = data;
  endtask

  task automatic clear_mon();
    mon_starts = 0; mon_done = 0; mon_err = 0;
  endtask

  task automatic wait_end(input string tag);
    bit timed_out = 1'b1;
    run_cycles = 0;
    for (int c = 0; c < 4000; c++) begin
      if (done || err) begin
        timed_out = 1'b0;
        run_cycles = c;
        break;
      end
      @(negedge clk);
    end
    check({tag, "_finished"}, 64'(timed_out), 64'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic run(input int n, input bit exp_busy, input string tag);
    clear_mon();
    len = 7'(n); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy"}, 64'(busy), 64'(exp_busy));
    wait_end(tag);
  endtask

  task automatic expect_run(input string tag, input longint exp_res, input int exp_starts,
                            input int exp_done, input int exp_err);
    check({tag, "_result"}, result, 64'(exp_res));
    check({tag, "_starts"}, 64'(mon_starts), 64'(exp_starts));
    check({tag, "_done"},   64'(mon_done),   64'(exp_done));
    check({tag, "_err"},    64'(mon_err),    64'(exp_err));
  endtask

  initial begin
    longint saved;
    int n;
    rst_n = 1'b0; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
    len = '0; start = 1'b0;
    clear_mon();
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_acc_start", 64'(acc_start), 64'd0);
    check("rst_result", result, 64'd0);
    check("rst_acc_ab", 64'(|{acc_a, acc_b}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Fill both buffers with noise so zero padding is meaningful.
    for (int i = 0; i < MAX_LEN; i++) begin
      wr(1'b0, i, int'($urandom));
      wr(1'b1, i, int'($urandom));
    end

    // 1: single chunk
    for (int i = 0; i < 8; i++) begin wr(1'b0, i, i + 1); wr(1'b1, i, 1); end
    run(8, 1'b1, "t1");
    expect_run("t1", 64'd36, 1, 1, 0);
    check("t1_ref", result, 64'(ref_dot(8)));

    // 2: three chunks, last one half padded
    for (int i = 0; i < 20; i++) begin wr(1'b0, i, i + 1); wr(1'b1, i, 2); end
    run(20, 1'b1, "t2");
    expect_run("t2", 64'd420, 3, 1, 0);
    for (int i = 0; i < 4; i++) check("t2_lane_live", 64'(last_a[i*32 +: 32]), 64'(17 + i));
    for (int i = 4; i < 8; i++) begin
      check("t2_pad_a", 64'(last_a[i*32 +: 32]), 64'd0);
      check("t2_pad_b", 64'(last_b[i*32 +: 32]), 64'd0);
    end

    // 3: negative result
    for (int i = 0; i < 8; i++) begin wr(1'b0, i, -3); wr(1'b1, i, 5); end
    run(8, 1'b1, "t3");
    expect_run("t3", -64'sd120, 1, 1, 0);
    check("t3_hex", result, 64'hFFFF_FFFF_FFFF_FF88);

    // 4: zero length then oversize length
    run(0, 1'b1, "t4z");
    expect_run("t4z", 64'd0, 0, 1, 0);
    run(65, 1'b0, "t4big");
    expect_run("t4big", 64'd0, 0, 0, 1);

    // Write and start in the same idle cycle: the run sees the new value.
    clear_mon();
    wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 6'd0; wr_data = 32'd7;
    len = 7'd8; start = 1'b1;
    @(negedge clk);
    wr_en = 1'b0; start = 1'b0;
    ref_a[0] = 7;
    wait_end("t_wrst");
    expect_run("t_wrst", ref_dot(8), 1, 1, 0);

    // 5: writes and starts while busy are dropped
    for (int i = 0; i < 16; i++) begin wr(1'b0, i, int'($urandom)); wr(1'b1, i, int'($urandom)); end
    clear_mon();
    len = 7'd16; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 6'd0; wr_data = 32'd100; start = 1'b1;
    @(negedge clk);
    wr_en = 1'b0; start = 1'b0;
    wait_end("t5a");
    expect_run("t5a", ref_dot(16), 2, 1, 0);
    run(16, 1'b1, "t5b");
    expect_run("t5b", ref_dot(16), 2, 1, 0);

    // Randomized lengths, data and accelerator latency.
    for (int r = 0; r < 6; r++) begin
      n = int'($urandom_range(1, MAX_LEN));
      for (int i = 0; i < n; i++) begin wr(1'b0, i, int'($urandom)); wr(1'b1, i, int'($urandom)); end
      run(n, 1'b1, "rnd");
      expect_run("rnd", ref_dot(n), (n + 7) / 8, 1, 0);
    end

    // 6a: accelerator never finishes
    saved = longint'(result);
    acc_hold_low = 1'b1;
    run(8, 1'b1, "t6tmo");
    expect_run("t6tmo", saved, 1, 0, 1);
    check("t6tmo_lo", 64'(run_cycles >= TIMEOUT), 64'd1);
    check("t6tmo_hi", 64'(run_cycles <= TIMEOUT + 6), 64'd1);

    // 6b: reset while waiting on the accelerator
    clear_mon();
    len = 7'd64; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    begin
      bit seen = 1'b0;
      for (int c = 0; c < 50; c++) begin
        if (acc_start) begin seen = 1'b1; break; end
        @(negedge clk);
      end
      check("t6rst_issue_seen", 64'(seen), 64'd1);
    end
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6rst_busy", 64'(busy), 64'd0);
    check("t6rst_done", 64'(done), 64'd0);
    check("t6rst_err", 64'(err), 64'd0);
    check("t6rst_acc_start", 64'(acc_start), 64'd0);
    check("t6rst_result", result, 64'd0);
    check("t6rst_acc_ab", 64'(|{acc_a, acc_b}), 64'd0);
    @(negedge clk);
    clear_mon();
    acc_hold_low = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("t6rst_no_done", 64'(mon_done), 64'd0);
    check("t6rst_no_err", 64'(mon_err), 64'd0);

    // Buffer contents survive reset.
    run(8, 1'b1, "post_rst");
    expect_run("post_rst", ref_dot(8), 1, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
